// File: rtl/alu_pkg.sv
// Shared ALU definitions: op-code bit positions, widths and the execute FSM states.
// The decode stage imports this package too, so both ends agree on the one-hot layout.
package alu_pkg;

    localparam int XLEN     = 32;
    localparam int ALU_OP_W = 11;

    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_AND  = 2;
    localparam int ALU_OR   = 3;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 5;
    localparam int ALU_SRL  = 6;
    localparam int ALU_SRA  = 7;
    localparam int ALU_SLT  = 8;
    localparam int ALU_SLTU = 9;
    localparam int ALU_RSVD = 10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    // Executable only when flagged valid, exactly one bit set, and not the reserved slot.
    function automatic logic op_is_legal(input logic [ALU_OP_W-1:0] op, input logic op_valid);
        return op_valid && (op != '0) && ((op & (op - 1'b1)) == '0) && !op[ALU_RSVD];
    endfunction

endpackage

// File: rtl/alu_comb32.sv
// Single-cycle datapath: add/sub/and/or/xor/slt/sltu selected by the one-hot op code.
// Shift and reserved codes produce zero here; the serial shifter lives in alu_exec32.
module alu_comb32
    import alu_pkg::*;
(
    input  logic [ALU_OP_W-1:0] op,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic [XLEN-1:0]     y
);

    logic unused_op_bits;
    assign unused_op_bits = ^{op[ALU_SLL], op[ALU_SRL], op[ALU_SRA], op[ALU_RSVD]};

    always_comb begin
        // NOTE: assign a default before any branch so no path leaves y unassigned (no latch).
        y = '0;
        if (op[ALU_ADD])       y = a + b;
        else if (op[ALU_SUB])  y = a - b;
        else if (op[ALU_AND])  y = a & b;
        else if (op[ALU_OR])   y = a | b;
        else if (op[ALU_XOR])  y = a ^ b;
        else if (op[ALU_SLT])  y = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
        else if (op[ALU_SLTU]) y = {{(XLEN-1){1'b0}}, a < b};
    end

endmodule

// File: rtl/alu_exec32.sv
// Multi-cycle execute unit: one-cycle ALU ops, bit-serial shifts (one position per clock),
// valid/ready handshake on both sides with a registered, backpressure-stable result.
module alu_exec32
    import alu_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [ALU_OP_W-1:0] op,
    input  logic                op_valid,
    input  logic [XLEN-1:0]     a,
    input  logic [XLEN-1:0]     b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [XLEN-1:0]     result,
    output logic                illegal
);

    alu_state_e      state;
    logic [XLEN-1:0] result_q;
    logic            illegal_q;
    logic [XLEN-1:0] shreg;
    logic [4:0]      cnt;
    logic            shift_left;
    logic            fill_bit;

    logic            accept;
    logic            legal;
    logic            is_shift;
    logic [XLEN-1:0] comb_y;
    logic [XLEN-1:0] shreg_next;

    alu_comb32 u_comb (
        .op (op),
        .a  (a),
        .b  (b),
        .y  (comb_y)
    );

    assign in_ready   = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    assign accept     = in_valid && in_ready;
    assign legal      = op_is_legal(op, op_valid);
    assign is_shift   = op[ALU_SLL] || op[ALU_SRL] || op[ALU_SRA];
    assign shreg_next = shift_left ? {shreg[XLEN-2:0], 1'b0} : {fill_bit, shreg[XLEN-1:1]};

    assign out_valid  = (state == ST_DONE);
    assign result     = result_q;
    assign illegal    = illegal_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            result_q   <= '0;
            illegal_q  <= 1'b0;
            shreg      <= '0;
            cnt        <= '0;
            shift_left <= 1'b0;
            fill_bit   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (!legal) begin
                            result_q  <= '0;
                            illegal_q <= 1'b1;
                            state     <= ST_DONE;
                        end else if (is_shift) begin
                            illegal_q  <= 1'b0;
                            shreg      <= a;
                            cnt        <= b[4:0];
                            shift_left <= op[ALU_SLL];
                            fill_bit   <= op[ALU_SRA] & a[XLEN-1];
                            if (b[4:0] == 5'd0) begin
                                result_q <= a;
                                state    <= ST_DONE;
                            end else begin
                                state    <= ST_SHIFT;
                            end
                        end else begin
                            result_q  <= comb_y;
                            illegal_q <= 1'b0;
                            state     <= ST_DONE;
                        end
                    end else if (state == ST_DONE && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    shreg <= shreg_next;
                    cnt   <= cnt - 5'd1;
                    // Final step publishes the shifted value directly.
                    if (cnt == 5'd1) begin
                        result_q <= shreg_next;
                        state    <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec32.sv
// Self-checking bench for alu_exec32: directed scenarios plus randomized requests
// compared against a behavioural model of result, illegal flag and latency.
module tb_alu_exec32;
    import alu_pkg::*;

    logic                clk;
    logic                rst_n;
    logic                in_valid;
    logic                in_ready;
    logic [ALU_OP_W-1:0] op;
    logic                op_valid;
    logic [XLEN-1:0]     a;
    logic [XLEN-1:0]     b;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     result;
    logic                illegal;

    int checks = 0;
    int errors = 0;

    alu_exec32 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op_valid  (op_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [XLEN:0] ref_out(input logic [ALU_OP_W-1:0] o, input logic ov,
                                              input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        logic [XLEN-1:0] r;
        if (!ov || $countones(o) != 1 || o[ALU_RSVD]) return {1'b1, 32'd0};
        r = 32'd0;
        case (1'b1)
            o[ALU_ADD]:  r = x + y;
            o[ALU_SUB]:  r = x - y;
            o[ALU_AND]:  r = x & y;
            o[ALU_OR]:   r = x | y;
            o[ALU_XOR]:  r = x ^ y;
            o[ALU_SLL]:  r = x << y[4:0];
            o[ALU_SRL]:  r = x >> y[4:0];
            o[ALU_SRA]:  r = $signed(x) >>> y[4:0];
            o[ALU_SLT]:  r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            o[ALU_SLTU]: r = (x < y) ? 32'd1 : 32'd0;
            default:     r = 32'd0;
        endcase
        return {1'b0, r};
    endfunction

    function automatic int ref_lat(input logic [ALU_OP_W-1:0] o, input logic ov, input logic [XLEN-1:0] y);
        bit legal_op;
        legal_op = ov && $countones(o) == 1 && !o[ALU_RSVD];
        if (legal_op && (o[ALU_SLL] || o[ALU_SRL] || o[ALU_SRA])) return 1 + int'(y[4:0]);
        return 1;
    endfunction

    // One request with out_ready held high; checks latency, result, illegal and busy in_ready.
    task automatic run_op(input string tag, input logic [ALU_OP_W-1:0] o, input logic ov,
                          input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        logic [XLEN:0] e;
        int            lat;
        int            exp_lat;
        logic          busy_ok;
        e       = ref_out(o, ov, x, y);
        exp_lat = ref_lat(o, ov, y);
        @(negedge clk);
        in_valid = 1'b1; op = o; op_valid = ov; a = x; b = y; out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        busy_ok = 1'b1;
        do begin
            @(negedge clk);
            lat++;
            if (!out_valid && in_ready) busy_ok = 1'b0;
        end while (!out_valid && lat < 40);
        check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "/result"}, result, e[XLEN-1:0]);
        check({tag, "/illegal"}, 32'(illegal), 32'(e[XLEN]));
        check({tag, "/busy_in_ready"}, 32'(busy_ok), 32'd1);
        check({tag, "/done_in_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [XLEN-1:0]     held;
        logic                stale;
        logic                stable;
        logic [ALU_OP_W-1:0] ro;
        logic                rv;
        int                  sel;

        rst_n = 1'b0; in_valid = 1'b0; op = '0; op_valid = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        #12;
        check("reset/in_ready", 32'(in_ready), 32'd1);
        check("reset/out_valid", 32'(out_valid), 32'd0);
        check("reset/result", result, 32'd0);
        check("reset/illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_wrap", 11'(1) << ALU_ADD, 1'b1, 32'hFFFF_FFFF, 32'd1);

        // slt then sltu accepted on consecutive edges
        @(negedge clk);
        in_valid = 1'b1; op = 11'(1) << ALU_SLT; op_valid = 1'b1; a = 32'h8000_0000; b = 32'd1;
        @(negedge clk);
        check("b2b/slt_valid", 32'(out_valid), 32'd1);
        check("b2b/slt_result", result, 32'd1);
        check("b2b/slt_in_ready", 32'(in_ready), 32'd1);
        op = 11'(1) << ALU_SLTU;
        @(negedge clk);
        check("b2b/sltu_valid", 32'(out_valid), 32'd1);
        check("b2b/sltu_result", result, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b/idle", 32'(out_valid), 32'd0);

        run_op("sra4", 11'(1) << ALU_SRA, 1'b1, 32'h8000_0010, 32'h0000_0024);
        run_op("sll0", 11'(1) << ALU_SLL, 1'b1, 32'd5, 32'd0);
        run_op("srl31", 11'(1) << ALU_SRL, 1'b1, 32'h8000_0000, 32'd31);
        run_op("sll31", 11'(1) << ALU_SLL, 1'b1, 32'h0000_0003, 32'hFFFF_FFFF);
        run_op("ill_twohot", 11'b000_0000_0011, 1'b1, 32'd7, 32'd9);
        run_op("ill_opvalid", 11'(1) << ALU_ADD, 1'b0, 32'd7, 32'd9);
        run_op("ill_rsvd", 11'(1) << ALU_RSVD, 1'b1, 32'd7, 32'd9);
        run_op("ill_zero", 11'd0, 1'b1, 32'd7, 32'd9);

        // Backpressure on an xor result
        @(negedge clk);
        in_valid = 1'b1; op = 11'(1) << ALU_XOR; op_valid = 1'b1;
        a = 32'hA5A5_0F0F; b = 32'hFFFF_0000; out_ready = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        held = 32'h5A5A_0F0F;
        stable = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (!out_valid || in_ready || result !== held || illegal !== 1'b0) stable = 1'b0;
        end
        check("bp/result", result, held);
        check("bp/stable", 32'(stable), 32'd1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp/released", 32'(out_valid), 32'd0);

        // Reset in the middle of a long shift
        in_valid = 1'b1; op = 11'(1) << ALU_SLL; op_valid = 1'b1; a = 32'd1; b = 32'd20;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst/shifting_in_ready", 32'(in_ready), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        check("rst/out_valid", 32'(out_valid), 32'd0);
        check("rst/in_ready", 32'(in_ready), 32'd1);
        check("rst/result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) stale = 1'b1;
        end
        check("rst/no_stale", 32'(stale), 32'd0);

        // Randomized requests
        for (int i = 0; i < 60; i++) begin
            sel = int'($urandom_range(0, 15));
            rv  = 1'b1;
            if (sel < 10)       ro = 11'(1) << sel;
            else if (sel == 10) ro = 11'(1) << ALU_RSVD;
            else if (sel == 11) ro = 11'($urandom);
            else if (sel == 12) begin ro = 11'(1) << $urandom_range(0, 9); rv = 1'b0; end
            else                ro = 11'(1) << $urandom_range(0, 9);
            run_op($sformatf("rand%0d", i), ro, rv, $urandom, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
